// File: rtl/adc_volt_conv_multi.sv
// Multi-channel offset-binary ADC code to signed millivolt converter with boxcar
// averaging, zero-offset calibration and a fixed 4-cycle scaling pipeline.
module adc_volt_conv_multi #(
  parameter int NUM_CH      = 2,
  parameter int ADC_W       = 12,
  parameter int OUT_W       = 16,
  parameter int AVG_LOG2    = 0,
  parameter int CAL_LOG2    = 4,
  parameter int SCALE_NUM   = 20000,
  parameter int SCALE_SHIFT = 13
) (
  input  logic                    ad_clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sample_en,
  input  logic                    cal_start,
  input  logic [NUM_CH*ADC_W-1:0] ad_in,
  output logic [NUM_CH*OUT_W-1:0] volt_out,
  output logic                    volt_valid,
  output logic [NUM_CH-1:0]       sat_flag,
  output logic                    cal_busy,
  output logic                    cal_done
);

  localparam int MAX_LOG2 = (AVG_LOG2 > CAL_LOG2) ? AVG_LOG2 : CAL_LOG2;
  localparam int ACC_W    = ADC_W + MAX_LOG2;
  localparam int CNT_W    = MAX_LOG2 + 1;
  localparam int CEN_W    = ADC_W + 2;
  localparam int OFF_W    = ADC_W + 1;
  localparam int MAG_W    = ADC_W + 1;
  localparam int SN_W     = $clog2(SCALE_NUM + 1);
  localparam int PROD_W   = MAG_W + SN_W;

  localparam logic [CNT_W-1:0]         AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]         CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);
  localparam logic signed [CEN_W-1:0]  MID_C    = CEN_W'(1 << (ADC_W - 1));
  localparam logic signed [OFF_W-1:0]  MID_O    = OFF_W'(1 << (ADC_W - 1));
  localparam logic [PROD_W-1:0]        SCALE_K  = PROD_W'(SCALE_NUM);
  localparam logic [PROD_W-1:0]        SAT_LIM  = PROD_W'((1 << (OUT_W - 1)) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CAL = 2'd2} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        acc      [NUM_CH];
  logic [ACC_W-1:0]        sum      [NUM_CH];
  logic [ADC_W-1:0]        cal_avg  [NUM_CH];
  logic signed [OFF_W-1:0] new_off  [NUM_CH];
  logic signed [OFF_W-1:0] offset   [NUM_CH];
  logic                    win_done, cal_fin, acc_clr, acc_add;

  logic [ACC_W-1:0]        win_sum  [NUM_CH];
  logic [ADC_W-1:0]        avg      [NUM_CH];
  logic signed [CEN_W-1:0] cen      [NUM_CH];
  logic [MAG_W-1:0]        mag      [NUM_CH];
  logic [PROD_W-1:0]       prod     [NUM_CH];
  logic [PROD_W-1:0]       shifted  [NUM_CH];
  logic [OUT_W-1:0]        lim_mag  [NUM_CH];
  logic [OUT_W-1:0]        res      [NUM_CH];
  logic [NUM_CH-1:0]       prod_neg, sat_s;
  logic                    win_v, avg_v, cen_v, prod_v;

  // State register
  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: dropping en always wins, cal_start only honoured in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = en ? RUN : IDLE;
      RUN:     if (!en) state_nxt = IDLE;
               else if (cal_start) state_nxt = CAL;
               else state_nxt = RUN;
      CAL:     if (!en) state_nxt = IDLE;
               else if (cal_fin) state_nxt = RUN;
               else state_nxt = CAL;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    win_done = (state == RUN) && en && !cal_start && sample_en && (cnt == AVG_LAST);
    cal_fin  = (state == CAL) && en && sample_en && (cnt == CAL_LAST);
    acc_clr  = !en || (state == IDLE) || ((state == RUN) && cal_start) || win_done || cal_fin;
    acc_add  = sample_en && ((state == RUN) || (state == CAL));
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]     = acc[i] + ACC_W'(ad_in[i*ADC_W +: ADC_W]);
      cal_avg[i] = ADC_W'(sum[i] >> CAL_LOG2);
      new_off[i] = $signed({1'b0, cal_avg[i]}) - MID_O;
    end
  end

  // Shared sample accumulator, used for averaging windows in RUN and the offset window in CAL
  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (acc_clr) begin
      cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (acc_add) begin
      cnt <= cnt + CNT_W'(1);
      for (int i = 0; i < NUM_CH; i++) acc[i] <= sum[i];
    end
  end

  // Offset registers only change on a completed calibration window
  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      cal_done <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) offset[i] <= '0;
    end else begin
      cal_done <= cal_fin;
      if (cal_fin) begin
        for (int i = 0; i < NUM_CH; i++) offset[i] <= new_off[i];
      end
    end
  end

  assign cal_busy = (state == CAL);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mag[i]     = cen[i][CEN_W-1] ? MAG_W'(-cen[i]) : MAG_W'(cen[i]);
      shifted[i] = prod[i] >> SCALE_SHIFT;
      sat_s[i]   = shifted[i] > SAT_LIM;
      lim_mag[i] = sat_s[i] ? OUT_W'(SAT_LIM) : OUT_W'(shifted[i]);
      res[i]     = prod_neg[i] ? -lim_mag[i] : lim_mag[i];
    end
  end

  // Scaling pipeline; scaling the magnitude keeps truncation symmetric about midscale
  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      win_v    <= 1'b0;
      avg_v    <= 1'b0;
      cen_v    <= 1'b0;
      prod_v   <= 1'b0;
      prod_neg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        win_sum[i] <= '0;
        avg[i]     <= '0;
        cen[i]     <= '0;
        prod[i]    <= '0;
      end
    end else begin
      win_v  <= win_done && en;
      avg_v  <= win_v && en;
      cen_v  <= avg_v && en;
      prod_v <= cen_v && en;
      for (int i = 0; i < NUM_CH; i++) begin
        if (win_done) win_sum[i] <= sum[i];
        avg[i]      <= ADC_W'(win_sum[i] >> AVG_LOG2);
        cen[i]      <= $signed({2'b00, avg[i]}) - MID_C - $signed({offset[i][OFF_W-1], offset[i]});
        prod[i]     <= PROD_W'(mag[i]) * SCALE_K;
        prod_neg[i] <= cen[i][CEN_W-1];
      end
    end
  end

  // Output register holds its last value whenever no new result arrives
  always_ff @(posedge ad_clk or posedge rst) begin
    if (rst) begin
      volt_out   <= '0;
      volt_valid <= 1'b0;
      sat_flag   <= '0;
    end else begin
      volt_valid <= prod_v && en;
      if (prod_v && en) begin
        sat_flag <= sat_s;
        for (int i = 0; i < NUM_CH; i++) volt_out[i*OUT_W +: OUT_W] <= res[i];
      end
    end
  end

endmodule

// File: tb/tb_adc_volt_conv_multi.sv
// Randomised and directed bench for adc_volt_conv_multi: three instances (default,
// OUT_W=12, AVG_LOG2=2) share stimulus and are compared to a transaction-level model.
module tb_adc_volt_conv_multi;

  logic        clk = 1'b0;
  logic        rst, en, sample_en, cal_start;
  logic [23:0] ad_in;

  logic [31:0] vo, vo_a;
  logic [23:0] vo_s;
  logic        vv, vv_s, vv_a, busy, done, busy_s, done_s, busy_a, done_a;
  logic [1:0]  sf, sf_s, sf_a;

  always #5 clk = ~clk;

  adc_volt_conv_multi dut (
    .ad_clk(clk), .rst(rst), .en(en), .sample_en(sample_en), .cal_start(cal_start),
    .ad_in(ad_in), .volt_out(vo), .volt_valid(vv), .sat_flag(sf),
    .cal_busy(busy), .cal_done(done));

  adc_volt_conv_multi #(.OUT_W(12)) dut_sat (
    .ad_clk(clk), .rst(rst), .en(en), .sample_en(sample_en), .cal_start(cal_start),
    .ad_in(ad_in), .volt_out(vo_s), .volt_valid(vv_s), .sat_flag(sf_s),
    .cal_busy(busy_s), .cal_done(done_s));

  adc_volt_conv_multi #(.AVG_LOG2(2)) dut_avg (
    .ad_clk(clk), .rst(rst), .en(en), .sample_en(sample_en), .cal_start(cal_start),
    .ad_in(ad_in), .volt_out(vo_a), .volt_valid(vv_a), .sat_flag(sf_a),
    .cal_busy(busy_a), .cal_done(done_a));

  typedef struct {int due; int v0; int v1;} ent_t;

  ent_t q[$], qa[$];
  int   cyc, n_cmp, n_fail;
  int   m_mode;
  int   off0, off1, a_sum0, a_sum1, a_n, c_sum0, c_sum1, c_n;
  logic        e_vv, e_vv_a, e_busy, e_done;
  logic [31:0] e_vo, e_vo_a;
  logic [23:0] e_vo_s;
  logic [1:0]  e_sf, e_sf_a, e_sf_s;

  logic [98:0] obs_vec, exp_vec;
  assign obs_vec = {vv, vo, sf, vv_s, vo_s, sf_s, vv_a, vo_a, sf_a, busy, done};
  assign exp_vec = {e_vv, e_vo, e_sf, e_vv, e_vo_s, e_sf_s, e_vv_a, e_vo_a, e_sf_a, e_busy, e_done};

  function automatic int to_mv(input int code, input int off);
    int c, m;
    c = code - 2048 - off;
    m = ((c < 0) ? -c : c) * 20000 / 8192;
    return (c < 0) ? -m : m;
  endfunction

  function automatic int clampv(input int v, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    return (v > lim) ? lim : ((v < -lim) ? -lim : v);
  endfunction

  function automatic logic is_sat(input int v, input int w);
    return (v != clampv(v, w));
  endfunction

  task automatic reset_model();
    q.delete(); qa.delete();
    m_mode = 0; off0 = 0; off1 = 0;
    a_sum0 = 0; a_sum1 = 0; a_n = 0; c_sum0 = 0; c_sum1 = 0; c_n = 0;
    e_vv = 0; e_vv_a = 0; e_busy = 0; e_done = 0;
    e_vo = '0; e_vo_a = '0; e_vo_s = '0; e_sf = '0; e_sf_a = '0; e_sf_s = '0;
  endtask

  // Model of one clock edge: mode 0 = off, 1 = converting, 2 = calibrating
  task automatic model_edge(input logic se, input logic cs, input int c0, input int c1);
    ent_t e;
    cyc++;
    e_vv = 0; e_vv_a = 0; e_done = 0;
    if (!en) begin
      q.delete(); qa.delete();
      m_mode = 0; a_sum0 = 0; a_sum1 = 0; a_n = 0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        e_vv   = 1;
        e_vo   = {16'(clampv(e.v1, 16)), 16'(clampv(e.v0, 16))};
        e_sf   = {is_sat(e.v1, 16), is_sat(e.v0, 16)};
        e_vo_s = {12'(clampv(e.v1, 12)), 12'(clampv(e.v0, 12))};
        e_sf_s = {is_sat(e.v1, 12), is_sat(e.v0, 12)};
      end
      if (qa.size() > 0 && qa[0].due == cyc) begin
        e = qa.pop_front();
        e_vv_a = 1;
        e_vo_a = {16'(clampv(e.v1, 16)), 16'(clampv(e.v0, 16))};
        e_sf_a = {is_sat(e.v1, 16), is_sat(e.v0, 16)};
      end
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (cs) begin
          m_mode = 2; c_sum0 = 0; c_sum1 = 0; c_n = 0;
          a_sum0 = 0; a_sum1 = 0; a_n = 0;
        end else if (se) begin
          q.push_back('{cyc + 4, to_mv(c0, off0), to_mv(c1, off1)});
          a_sum0 += c0; a_sum1 += c1; a_n++;
          if (a_n == 4) begin
            qa.push_back('{cyc + 4, to_mv(a_sum0 / 4, off0), to_mv(a_sum1 / 4, off1)});
            a_sum0 = 0; a_sum1 = 0; a_n = 0;
          end
        end
      end else if (se) begin
        c_sum0 += c0; c_sum1 += c1; c_n++;
        if (c_n == 16) begin
          off0 = c_sum0 / 16 - 2048;
          off1 = c_sum1 / 16 - 2048;
          m_mode = 1; e_done = 1;
        end
      end
    end
    e_busy = (m_mode == 2);
  endtask

  task automatic step(input logic se, input logic cs, input logic [11:0] c0, input logic [11:0] c1);
    sample_en = se; cal_start = cs; ad_in = {c1, c0};
    @(posedge clk);
    model_edge(se, cs, int'(c0), int'(c1));
    #1;
  endtask

  task automatic test_reset();
    rst = 0; en = 0; sample_en = 0; cal_start = 0; ad_in = '0;
    #2 rst = 1;
    #1 reset_model();
    if (obs_vec !== 99'd0) begin n_fail++; $display("FAIL reset_async got=%h exp=0", obs_vec); end
    n_cmp++;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 12'hFFF, 12'hFFF);
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
    end
  endtask

  task automatic test_spec_vectors();
    logic [11:0] s0 [8] = '{12'h800, 12'h000, 12'h800, 12'h800, 12'h0, 12'h0, 12'h0, 12'h0};
    logic [11:0] s1 [8] = '{12'hFFF, 12'h801, 12'h7FF, 12'h800, 12'h0, 12'h0, 12'h0, 12'h0};
    logic [31:0] k_vo  [4] = '{32'h1385_0000, 32'h0002_EC78, 32'hFFFE_0000, 32'h0000_0000};
    logic [23:0] k_vos [4] = '{24'h7FF_000, 24'h002_801, 24'hFFE_000, 24'h000_000};
    logic [1:0]  k_sfs [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    en = 1;
    step(1'b0, 1'b0, 12'h0, 12'h0);
    for (int i = 0; i < 8; i++) begin
      step(i < 4, 1'b0, s0[i], s1[i]);
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL spec_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
      if (i >= 4) begin
        if ({vv, vo, vv_s, vo_s, sf_s} !== {1'b1, k_vo[i-4], 1'b1, k_vos[i-4], k_sfs[i-4]}) begin
          n_fail++;
          $display("FAIL spec_const idx=%0d got=%h/%h/%b exp=%h/%h/%b", i, vo, vo_s, sf_s, k_vo[i-4], k_vos[i-4], k_sfs[i-4]);
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_avg();
    logic [11:0] pat [4] = '{12'h800, 12'h800, 12'h900, 12'h900};
    logic [31:0] last = '0;
    int k = 0, nv = 0;
    for (int i = 0; i < 20; i++) begin
      logic se;
      se = (k < 4) && ((i % 2 == 0) || ($urandom_range(0, 1) == 1));
      step(se, 1'b0, se ? pat[k] : 12'($urandom), se ? 12'h800 : 12'($urandom));
      if (se) k++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL avg_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
      if (vv_a) begin nv++; last = vo_a; end
    end
    if (nv !== 1 || last !== 32'h0000_0138) begin
      n_fail++; $display("FAIL avg_const got=%0d/%h exp=1/00000138", nv, last);
    end
    n_cmp++;
  endtask

  task automatic test_cal();
    int k = 0, nd = 0;
    step(1'b0, 1'b1, 12'h810, 12'h810);
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL cal_entry cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
    n_cmp++;
    for (int i = 0; i < 30; i++) begin
      logic se;
      se = (k < 16) && (i % 3 != 2);
      step(se, 1'b0, 12'h810, 12'h810);
      if (se) k++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL cal_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
      if (done) nd++;
    end
    if (nd !== 1) begin n_fail++; $display("FAIL cal_done_count got=%0d exp=1", nd); end
    n_cmp++;
    for (int i = 0; i < 6; i++) begin
      step(i < 2, 1'b0, (i == 0) ? 12'h810 : 12'h820, (i == 0) ? 12'h810 : 12'h820);
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL cal_use cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
      if (i >= 4 && vo !== ((i == 4) ? 32'h0000_0000 : 32'h0027_0027)) begin
        n_fail++; $display("FAIL cal_const idx=%0d got=%h", i, vo);
      end
      if (i >= 4) n_cmp++;
    end
  endtask

  task automatic test_abort_and_reset();
    int nd = 0;
    step(1'b0, 1'b1, 12'h0, 12'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 12'h900, 12'h900);
      if (done) nd++;
    end
    en = 0;
    step(1'b1, 1'b0, 12'h900, 12'h900);
    if (done) nd++;
    if (obs_vec !== exp_vec || nd !== 0) begin n_fail++; $display("FAIL cal_abort cyc=%0d nd=%0d got=%h exp=%h", cyc, nd, obs_vec, exp_vec); end
    n_cmp++;
    en = 1;
    for (int i = 0; i < 6; i++) begin
      step(i == 1, 1'b0, 12'h820, 12'h820);
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL abort_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
    end
    if (vo !== 32'h0027_0027) begin n_fail++; $display("FAIL abort_offset_kept got=%h exp=00270027", vo); end
    n_cmp++;
    step(1'b1, 1'b0, 12'h900, 12'h900);
    step(1'b1, 1'b0, 12'h900, 12'h900);
    rst = 1;
    #1 reset_model();
    if (obs_vec !== 99'd0) begin n_fail++; $display("FAIL rst_midrun got=%h exp=0", obs_vec); end
    n_cmp++;
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 7; i++) begin
      step(i == 1, 1'b0, 12'h820, 12'h820);
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL post_rst cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
      if (i == 5 && vo !== 32'h004E_004E) begin n_fail++; $display("FAIL post_rst_offset got=%h exp=004e004e", vo); end
      if (i == 5) n_cmp++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      step(i < 12, 1'b0, 12'($urandom), 12'($urandom));
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) en = !en;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 12'($urandom), 12'($urandom));
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
      n_cmp++;
    end
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_fail = 0;
    reset_model();
    test_reset();
    test_spec_vectors();
    test_avg();
    test_cal();
    test_abort_and_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
